// File: rtl/swt16_pkg.sv
// swt16_pkg: shared width defaults and memory geometry for the swt16 pipeline.
// Holds the default parameter values used by mem_access and dmem_2r1w,
// the data-memory depth and the lowest byte-address bit used for word indexing.
package swt16_pkg;

  localparam int DMEM_ADDR_WIDTH_DEF = 12;
  localparam int DMEM_WORD_WIDTH_DEF = 16;
  localparam int IALU_WORD_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF        = 12;
  localparam int PMEM_WORD_WIDTH_DEF = 16;
  localparam int REG_IDX_WIDTH_DEF   = 4;

  // Data memory is word-organised; one byte-address bit is dropped for indexing.
  localparam int DMEM_WORDS = 2 ** (DMEM_ADDR_WIDTH_DEF - 1);

  // Word index = byte address[DMEM_ADDR_WIDTH-1:WORD_IDX_LSB].
  localparam int WORD_IDX_LSB = 1;

endpackage

// File: rtl/mem_access_dmem_2r1w.sv
// dmem_2r1w: synchronous data memory, two registered read ports, one write port.
// Ports: clock/reset; rd0_en/rd0_idx/rd0_word (enabled, holds when idle);
//        rd1_idx/rd1_word (reads every cycle); wr_en/wr_idx/wr_word.
// Reads see the contents before a same-edge write (read-before-write).
module dmem_2r1w
  import swt16_pkg::*;
#(
  parameter int IDX_WIDTH  = DMEM_ADDR_WIDTH_DEF - 1,
  parameter int WORD_WIDTH = DMEM_WORD_WIDTH_DEF,
  parameter int WORDS      = DMEM_WORDS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd0_en,
  input  logic [IDX_WIDTH-1:0]  rd0_idx,
  output logic [WORD_WIDTH-1:0] rd0_word,
  input  logic [IDX_WIDTH-1:0]  rd1_idx,
  output logic [WORD_WIDTH-1:0] rd1_word,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_word
);

  logic [WORD_WIDTH-1:0] mem [WORDS];

  // Storage has no reset; a write presented while reset is high is dropped
  // so a reset pulse never corrupts memory contents.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd0_word <= '0;
      rd1_word <= '0;
    end else begin
      if (rd0_en) begin
        rd0_word <= mem[rd0_idx];
      end
      rd1_word <= mem[rd1_idx];
    end
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the swt16 pipeline. Registers the execute
// result, performs loads/stores on the data memory and muxes the write-back word.
// Ports: in_act_* request flags, load/store addresses and data, pass-through
//   instr/pc/res/res_reg_idx; out_* write-back, sticky out_misaligned,
//   registered debug read (in_dbg_rd_addr -> out_dbg_rd_word), forwarding tap.
// Optional feature: define MEM_ACCESS_FWD_EN to drive the forwarding tap from
//   the write-back outputs; otherwise the tap ports are tied to 0.
module mem_access
  import swt16_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
  parameter int DMEM_WORD_WIDTH = DMEM_WORD_WIDTH_DEF,
  parameter int IALU_WORD_WIDTH = IALU_WORD_WIDTH_DEF,
  parameter int PC_WIDTH        = PC_WIDTH_DEF,
  parameter int PMEM_WORD_WIDTH = PMEM_WORD_WIDTH_DEF,
  parameter int REG_IDX_WIDTH   = REG_IDX_WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dbg_rd_addr,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_misaligned,
  output logic [DMEM_WORD_WIDTH-1:0] out_dbg_rd_word,
  output logic                       out_fwd_valid,
  output logic [REG_IDX_WIDTH-1:0]   out_fwd_idx,
  output logic [IALU_WORD_WIDTH-1:0] out_fwd_word
);

  localparam int IDX_WIDTH = DMEM_ADDR_WIDTH - WORD_IDX_LSB;

  logic                       load_ff;
  logic                       write_res_ff;
  logic [IALU_WORD_WIDTH-1:0] res_ff;
  logic [REG_IDX_WIDTH-1:0]   res_reg_idx_ff;
  logic [PMEM_WORD_WIDTH-1:0] instr_ff;
  logic [PC_WIDTH-1:0]        pc_ff;
  logic [DMEM_WORD_WIDTH-1:0] rd_word_ff;
  logic                       misaligned_ff;
  logic                       misaligned_now;

  // Debug address bit 0 has no meaning for a word-wide read port.
  logic unused_dbg_addr_bit0;
  assign unused_dbg_addr_bit0 = in_dbg_rd_addr[0];

  dmem_2r1w #(
    .IDX_WIDTH  (IDX_WIDTH),
    .WORD_WIDTH (DMEM_WORD_WIDTH),
    .WORDS      (2 ** IDX_WIDTH)
  ) u_dmem (
    .clock    (clock),
    .reset    (reset),
    .rd0_en   (in_act_load_dmem),
    .rd0_idx  (in_dmem_rd_addr[DMEM_ADDR_WIDTH-1:WORD_IDX_LSB]),
    .rd0_word (rd_word_ff),
    .rd1_idx  (in_dbg_rd_addr[DMEM_ADDR_WIDTH-1:WORD_IDX_LSB]),
    .rd1_word (out_dbg_rd_word),
    .wr_en    (in_act_store_dmem),
    .wr_idx   (in_dmem_wr_addr[DMEM_ADDR_WIDTH-1:WORD_IDX_LSB]),
    .wr_word  (in_dmem_wr_word)
  );

  // An odd byte address on any live request flags an error; the access itself
  // still goes ahead on the containing word.
  assign misaligned_now = (in_act_store_dmem && in_dmem_wr_addr[0]) ||
                          (in_act_load_dmem  && in_dmem_rd_addr[0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_ff        <= 1'b0;
      write_res_ff   <= 1'b0;
      res_ff         <= '0;
      res_reg_idx_ff <= '0;
      instr_ff       <= '0;
      pc_ff          <= '0;
      misaligned_ff  <= 1'b0;
    end else begin
      load_ff        <= in_act_load_dmem;
      write_res_ff   <= in_act_write_res_to_reg;
      res_ff         <= in_res;
      res_reg_idx_ff <= in_res_reg_idx;
      instr_ff       <= in_instr;
      pc_ff          <= in_pc;
      if (misaligned_now) begin
        misaligned_ff <= 1'b1;
      end
    end
  end

  assign out_res                  = load_ff ? IALU_WORD_WIDTH'(rd_word_ff) : res_ff;
  assign out_act_write_res_to_reg = write_res_ff;
  assign out_res_reg_idx          = res_reg_idx_ff;
  assign out_instr                = instr_ff;
  assign out_pc                   = pc_ff;
  assign out_misaligned           = misaligned_ff;

`ifdef MEM_ACCESS_FWD_EN
  assign out_fwd_valid = out_act_write_res_to_reg;
  assign out_fwd_idx   = out_res_reg_idx;
  assign out_fwd_word  = out_res;
`else
  assign out_fwd_valid = 1'b0;
  assign out_fwd_idx   = '0;
  assign out_fwd_word  = '0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access.
// Inputs are driven 1ns after each rising edge and outputs are checked there,
// so each check observes the state captured at the preceding edge.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
  logic [11:0] in_dmem_rd_addr, in_dmem_wr_addr, in_dbg_rd_addr, in_pc;
  logic [15:0] in_dmem_wr_word, in_instr, in_res;
  logic [3:0]  in_res_reg_idx;
  logic        out_act_write_res_to_reg, out_misaligned, out_fwd_valid;
  logic [15:0] out_res, out_instr, out_dbg_rd_word, out_fwd_word;
  logic [3:0]  out_res_reg_idx, out_fwd_idx;
  logic [11:0] out_pc;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_access dut (
    .clock                    (clock),
    .reset                    (reset),
    .in_act_load_dmem         (in_act_load_dmem),
    .in_act_store_dmem        (in_act_store_dmem),
    .in_act_write_res_to_reg  (in_act_write_res_to_reg),
    .in_dmem_rd_addr          (in_dmem_rd_addr),
    .in_dmem_wr_addr          (in_dmem_wr_addr),
    .in_dmem_wr_word          (in_dmem_wr_word),
    .in_instr                 (in_instr),
    .in_pc                    (in_pc),
    .in_res                   (in_res),
    .in_res_reg_idx           (in_res_reg_idx),
    .in_dbg_rd_addr           (in_dbg_rd_addr),
    .out_act_write_res_to_reg (out_act_write_res_to_reg),
    .out_res                  (out_res),
    .out_res_reg_idx          (out_res_reg_idx),
    .out_instr                (out_instr),
    .out_pc                   (out_pc),
    .out_misaligned           (out_misaligned),
    .out_dbg_rd_word          (out_dbg_rd_word),
    .out_fwd_valid            (out_fwd_valid),
    .out_fwd_idx              (out_fwd_idx),
    .out_fwd_word             (out_fwd_word)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_act_load_dmem        = 1'b0;
    in_act_store_dmem       = 1'b0;
    in_act_write_res_to_reg = 1'b0;
    in_dmem_rd_addr         = '0;
    in_dmem_wr_addr         = '0;
    in_dmem_wr_word         = '0;
    in_instr                = '0;
    in_pc                   = '0;
    in_res                  = '0;
    in_res_reg_idx          = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_dbg_rd_addr = '0;
    for (int i = 0; i < 4; i++) begin
      in_act_load_dmem        = 1'($urandom);
      in_act_store_dmem       = 1'($urandom);
      in_act_write_res_to_reg = 1'($urandom);
      in_dmem_rd_addr         = 12'($urandom);
      in_dmem_wr_addr         = 12'($urandom);
      in_dmem_wr_word         = 16'($urandom);
      in_instr                = 16'($urandom);
      in_pc                   = 12'($urandom);
      in_res                  = 16'($urandom);
      in_res_reg_idx          = 4'($urandom);
      in_dbg_rd_addr          = 12'($urandom);
      if (i == 0) #1; else step();
      checks++;
      if ({out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc,
           out_misaligned, out_dbg_rd_word, out_fwd_valid, out_fwd_idx, out_fwd_word} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d wb=%b res=%h idx=%h instr=%h pc=%h mis=%b dbg=%h fwd=%b/%h/%h required all 0",
                 i, out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc,
                 out_misaligned, out_dbg_rd_word, out_fwd_valid, out_fwd_idx, out_fwd_word);
      end
    end
    idle();
    in_dbg_rd_addr = '0;
    reset = 1'b0;
    step();
    checks++;
    if (out_misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_release_misaligned got=%b exp=0", out_misaligned);
    end
  endtask

  task automatic check_fwd(input string name, input logic v, input logic [3:0] idx, input logic [15:0] w);
    logic       ev;
    logic [3:0] ei;
    logic [15:0] ew;
`ifdef MEM_ACCESS_FWD_EN
    ev = v; ei = idx; ew = w;
`else
    ev = 1'b0; ei = 4'h0; ew = 16'h0;
    if (v === 1'bx) ev = 1'b0;
`endif
    checks++;
    if ({out_fwd_valid, out_fwd_idx, out_fwd_word} !== {ev, ei, ew}) begin
      failures++;
      $display("FAIL %s got=%b/%h/%h exp=%b/%h/%h", name, out_fwd_valid, out_fwd_idx, out_fwd_word, ev, ei, ew);
    end
  endtask

  task automatic test_alu();
    idle();
    in_res = 16'h1234; in_res_reg_idx = 4'd5; in_act_write_res_to_reg = 1'b1;
    in_instr = 16'hA5A5; in_pc = 12'h123;
    step();
    idle();
    checks++;
    if ({out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc} !==
        {1'b1, 16'h1234, 4'd5, 16'hA5A5, 12'h123}) begin
      failures++;
      $display("FAIL alu_wb got=%b/%h/%h/%h/%h exp=1/1234/5/a5a5/123",
               out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc);
    end
    check_fwd("alu_fwd", 1'b1, 4'd5, 16'h1234);
    in_res = 16'hFFFF; in_res_reg_idx = 4'd15; in_act_write_res_to_reg = 1'b0;
    in_instr = 16'h0F0F; in_pc = 12'hFFE;
    step();
    idle();
    checks++;
    if ({out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc} !==
        {1'b0, 16'hFFFF, 4'd15, 16'h0F0F, 12'hFFE}) begin
      failures++;
      $display("FAIL alu_nowb got=%b/%h/%h/%h/%h exp=0/ffff/f/0f0f/ffe",
               out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc);
    end
    check_fwd("alu_nowb_fwd", 1'b0, 4'd15, 16'hFFFF);
  endtask

  task automatic test_store_load();
    idle();
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h010; in_dmem_wr_word = 16'hBEEF;
    in_dbg_rd_addr = 12'h010;
    step();
    idle();
    in_act_load_dmem = 1'b1; in_dmem_rd_addr = 12'h010;
    in_act_write_res_to_reg = 1'b1; in_res_reg_idx = 4'd3; in_res = 16'h5555;
    step();
    idle();
    checks++;
    if (out_res !== 16'hBEEF) begin
      failures++; $display("FAIL store_load_res got=%h exp=beef", out_res);
    end
    checks++;
    if (out_dbg_rd_word !== 16'hBEEF) begin
      failures++; $display("FAIL store_load_dbg got=%h exp=beef", out_dbg_rd_word);
    end
    check_fwd("load_fwd", 1'b1, 4'd3, 16'hBEEF);
  endtask

  task automatic test_same_word();
    idle();
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h020; in_dmem_wr_word = 16'h0001;
    step();
    idle();
    in_act_load_dmem = 1'b1; in_dmem_rd_addr = 12'h020;
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h020; in_dmem_wr_word = 16'h00FF;
    in_dbg_rd_addr = 12'h020;
    step();
    idle();
    checks++;
    if (out_res !== 16'h0001) begin
      failures++; $display("FAIL same_word_load got=%h exp=0001", out_res);
    end
    step();
    checks++;
    if (out_dbg_rd_word !== 16'h00FF) begin
      failures++; $display("FAIL same_word_dbg got=%h exp=00ff", out_dbg_rd_word);
    end
    // Different words in the same cycle: both complete.
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h040; in_dmem_wr_word = 16'h1111;
    step();
    idle();
    in_act_load_dmem = 1'b1; in_dmem_rd_addr = 12'h040;
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h042; in_dmem_wr_word = 16'h2222;
    in_dbg_rd_addr = 12'h042;
    step();
    idle();
    checks++;
    if (out_res !== 16'h1111) begin
      failures++; $display("FAIL diff_word_load got=%h exp=1111", out_res);
    end
    step();
    checks++;
    if (out_dbg_rd_word !== 16'h2222) begin
      failures++; $display("FAIL diff_word_dbg got=%h exp=2222", out_dbg_rd_word);
    end
    checks++;
    if (out_misaligned !== 1'b0) begin
      failures++; $display("FAIL aligned_no_flag got=%b exp=0", out_misaligned);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h050; in_dmem_wr_word = 16'h3C3C;
    step();
    idle();
    in_act_load_dmem = 1'b1; in_dmem_rd_addr = 12'h050;
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h052; in_dmem_wr_word = 16'h4D4D;
    step();
    idle();
    checks++;
    if (out_res !== 16'h3C3C) begin
      failures++; $display("FAIL b2b_load0 got=%h exp=3c3c", out_res);
    end
    in_act_load_dmem = 1'b1; in_dmem_rd_addr = 12'h052;
    step();
    idle();
    checks++;
    if (out_res !== 16'h4D4D) begin
      failures++; $display("FAIL b2b_load1 got=%h exp=4d4d", out_res);
    end
    in_res = 16'h0BAD;
    step();
    idle();
    checks++;
    if (out_res !== 16'h0BAD) begin
      failures++; $display("FAIL b2b_alu_after_load got=%h exp=0bad", out_res);
    end
  endtask

  task automatic test_misaligned();
    idle();
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h011; in_dmem_wr_word = 16'hCAFE;
    in_dbg_rd_addr = 12'h010;
    step();
    idle();
    checks++;
    if (out_misaligned !== 1'b1) begin
      failures++; $display("FAIL misaligned_set got=%b exp=1", out_misaligned);
    end
    step();
    checks++;
    if (out_dbg_rd_word !== 16'hCAFE) begin
      failures++; $display("FAIL misaligned_store_word got=%h exp=cafe", out_dbg_rd_word);
    end
    in_dbg_rd_addr = 12'h011;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (out_misaligned !== 1'b1) begin
      failures++; $display("FAIL misaligned_sticky got=%b exp=1", out_misaligned);
    end
    checks++;
    if (out_dbg_rd_word !== 16'hCAFE) begin
      failures++; $display("FAIL dbg_odd_addr got=%h exp=cafe", out_dbg_rd_word);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h030; in_dmem_wr_word = 16'h7777;
    step();
    in_dmem_wr_word = 16'h9999;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    in_dbg_rd_addr = 12'h030;
    step();
    checks++;
    if (out_dbg_rd_word !== 16'h7777) begin
      failures++; $display("FAIL reset_store_discarded got=%h exp=7777", out_dbg_rd_word);
    end
    checks++;
    if (out_misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_clears_misaligned got=%b exp=0", out_misaligned);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    in_dbg_rd_addr = '0;
    test_reset();
    test_alu();
    test_store_load();
    test_same_word();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
